// File: rtl/life_evo_sequencer.sv
// life_evo_sequencer: run-control sequencer for the Life datapath.
// Owns the game FSM, the programmable evolution tick, ping-pong bank select,
// single-step, generation counter and the edit cursor.
//
// Optional feature macro: CURSOR_WRAP_EN
//   defined   -> cursor moves wrap around the grid edges
//   undefined -> cursor saturates at the edges
//
// Ports:
//   clk_vga, reset_btn (async, active-high)
//   cmd_start/cmd_pause/cmd_clear/cmd_step : command pulses
//   cmd_manual : level, edit mode requested
//   dir        : one-hot cursor move {D,S,W,A}
//   speed_sel  : generation period = TICK_PERIOD << speed_sel
//   init_busy, round_busy : engine status
//   state      : 0 RST, 1 RUN, 2 PAUSE, 3 SETTING, 4 STEP
//   evo_bank, evo_start, clear_req : datapath control
//   cursor_x, cursor_y, cursor_addr : edit cursor
//   generation : completed generations since clear
//   overrun    : sticky, tick expired while round engine busy
module life_evo_sequencer #(
  parameter int unsigned GRID_W      = 800,
  parameter int unsigned GRID_H      = 600,
  parameter int unsigned ADDR_W      = 24,
  parameter int unsigned TICK_PERIOD = 5000000,
  parameter int unsigned GEN_W       = 16
) (
  input  logic              clk_vga,
  input  logic              reset_btn,
  input  logic              cmd_start,
  input  logic              cmd_pause,
  input  logic              cmd_clear,
  input  logic              cmd_step,
  input  logic              cmd_manual,
  input  logic [3:0]        dir,
  input  logic [1:0]        speed_sel,
  input  logic              init_busy,
  input  logic              round_busy,
  output logic [2:0]        state,
  output logic              evo_bank,
  output logic              evo_start,
  output logic              clear_req,
  output logic [11:0]       cursor_x,
  output logic [11:0]       cursor_y,
  output logic [ADDR_W-1:0] cursor_addr,
  output logic [GEN_W-1:0]  generation,
  output logic              overrun
);

  typedef enum logic [2:0] {
    StRst     = 3'd0,
    StRun     = 3'd1,
    StPause   = 3'd2,
    StSetting = 3'd3,
    StStep    = 3'd4
  } state_e;

  // Longest period is TICK_PERIOD << 3.
  localparam int unsigned TICK_W = $clog2(TICK_PERIOD * 8);

  localparam logic [11:0]       XMax     = 12'(GRID_W - 1);
  localparam logic [11:0]       YMax     = 12'(GRID_H - 1);
  localparam logic [11:0]       XInit    = 12'(GRID_W / 2);
  localparam logic [11:0]       YInit    = 12'(GRID_H / 2);
  localparam logic [ADDR_W-1:0] AddrInit = ADDR_W'((GRID_H / 2) * GRID_W + GRID_W / 2);
  localparam logic [ADDR_W-1:0] RowStep  = ADDR_W'(GRID_W);
  localparam logic [ADDR_W-1:0] ColSpan  = ADDR_W'(GRID_W - 1);
  localparam logic [ADDR_W-1:0] RowSpan  = ADDR_W'((GRID_H - 1) * GRID_W);

  state_e              state_q, state_d, ret_q, ret_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic                bank_q, bank_d;
  logic                evo_q, evo_d;
  logic                clr_q, clr_d;
  logic [GEN_W-1:0]    gen_q, gen_d;
  logic                ovr_q, ovr_d;
  logic [11:0]         x_q, x_d, y_q, y_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         period_m1;
  logic                tick_done;
  logic                do_clear;

  // speed_sel is read live; >= makes a lowered period fire on the next cycle.
  assign period_m1 = (32'(TICK_PERIOD) << speed_sel) - 32'd1;
  assign tick_done = 32'(tick_q) >= period_m1;

  always_comb begin
    state_d  = state_q;
    ret_d    = ret_q;
    tick_d   = tick_q;
    bank_d   = bank_q;
    evo_d    = 1'b0;
    clr_d    = 1'b0;
    gen_d    = gen_q;
    ovr_d    = ovr_q;
    x_d      = x_q;
    y_d      = y_q;
    addr_d   = addr_q;
    do_clear = 1'b0;

    unique case (state_q)
      StRst: begin
        if (!init_busy) begin
          if (cmd_start) begin
            state_d = StPause;
          end else if (cmd_manual) begin
            state_d = StSetting;
            ret_d   = StRst;
          end
        end
      end
      StRun: begin
        if (cmd_clear) begin
          do_clear = 1'b1;
        end else if (cmd_pause) begin
          state_d = StPause;
        end else if (tick_done) begin
          if (!round_busy) begin
            tick_d = '0;
            bank_d = ~bank_q;
            evo_d  = 1'b1;
            gen_d  = gen_q + GEN_W'(1);
          end else begin
            ovr_d = 1'b1;  // tick holds until the engine is free
          end
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      StPause: begin
        if (cmd_clear) begin
          do_clear = 1'b1;
        end else if (cmd_pause) begin
          state_d = StPause;
        end else if (cmd_step) begin
          state_d = StStep;
          bank_d  = ~bank_q;
          evo_d   = 1'b1;
          gen_d   = gen_q + GEN_W'(1);
        end else if (cmd_start) begin
          state_d = StRun;
        end else if (cmd_manual) begin
          state_d = StSetting;
          ret_d   = StPause;
        end
      end
      StStep: begin
        // Entry cycle is marked by evo_q; engine busy only shows after it.
        if (cmd_clear) begin
          do_clear = 1'b1;
        end else if (!evo_q && !round_busy) begin
          state_d = StPause;
        end
      end
      StSetting: begin
        if (cmd_clear) begin
          do_clear = 1'b1;
        end else if (!cmd_manual) begin
          state_d = ret_q;
        end else begin
          unique case (dir)
            4'b0001: begin  // A
              if (x_q != '0) begin
                x_d    = x_q - 12'd1;
                addr_d = addr_q - ADDR_W'(1);
              end
`ifdef CURSOR_WRAP_EN
              else begin
                x_d    = XMax;
                addr_d = addr_q + ColSpan;
              end
`endif
            end
            4'b1000: begin  // D
              if (x_q != XMax) begin
                x_d    = x_q + 12'd1;
                addr_d = addr_q + ADDR_W'(1);
              end
`ifdef CURSOR_WRAP_EN
              else begin
                x_d    = '0;
                addr_d = addr_q - ColSpan;
              end
`endif
            end
            4'b0010: begin  // W
              if (y_q != '0) begin
                y_d    = y_q - 12'd1;
                addr_d = addr_q - RowStep;
              end
`ifdef CURSOR_WRAP_EN
              else begin
                y_d    = YMax;
                addr_d = addr_q + RowSpan;
              end
`endif
            end
            4'b0100: begin  // S
              if (y_q != YMax) begin
                y_d    = y_q + 12'd1;
                addr_d = addr_q + RowStep;
              end
`ifdef CURSOR_WRAP_EN
              else begin
                y_d    = '0;
                addr_d = addr_q - RowSpan;
              end
`endif
            end
            default: begin
            end
          endcase
        end
      end
      default: state_d = StRst;
    endcase

    if (do_clear) begin
      state_d = StRst;
      tick_d  = '0;
      bank_d  = 1'b0;
      evo_d   = 1'b0;
      gen_d   = '0;
      ovr_d   = 1'b0;
      clr_d   = 1'b1;
    end
  end

  always_ff @(posedge clk_vga or posedge reset_btn) begin
    if (reset_btn) begin
      state_q <= StRst;
      ret_q   <= StRst;
      tick_q  <= '0;
      bank_q  <= 1'b0;
      evo_q   <= 1'b0;
      clr_q   <= 1'b0;
      gen_q   <= '0;
      ovr_q   <= 1'b0;
      x_q     <= XInit;
      y_q     <= YInit;
      addr_q  <= AddrInit;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      tick_q  <= tick_d;
      bank_q  <= bank_d;
      evo_q   <= evo_d;
      clr_q   <= clr_d;
      gen_q   <= gen_d;
      ovr_q   <= ovr_d;
      x_q     <= x_d;
      y_q     <= y_d;
      addr_q  <= addr_d;
    end
  end

  assign state       = state_q;
  assign evo_bank    = bank_q;
  assign evo_start   = evo_q;
  assign clear_req   = clr_q;
  assign cursor_x    = x_q;
  assign cursor_y    = y_q;
  assign cursor_addr = addr_q;
  assign generation  = gen_q;
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_life_evo_sequencer.sv
// Scoreboard bench for life_evo_sequencer: a behavioural model predicts every
// registered output per clock, a monitor pops and compares after each edge.
module tb_life_evo_sequencer;

  localparam int GW = 10;
  localparam int GH = 7;
  localparam int AW = 8;
  localparam int TP = 4;
  localparam int GN = 4;
`ifdef CURSOR_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  localparam int S_RST = 0, S_RUN = 1, S_PAUSE = 2, S_SET = 3, S_STEP = 4;

  logic          clk_vga = 1'b0;
  logic          reset_btn;
  logic          cmd_start, cmd_pause, cmd_clear, cmd_step, cmd_manual;
  logic [3:0]    dir;
  logic [1:0]    speed_sel;
  logic          init_busy, round_busy;
  logic [2:0]    state;
  logic          evo_bank, evo_start, clear_req, overrun;
  logic [11:0]   cursor_x, cursor_y;
  logic [AW-1:0] cursor_addr;
  logic [GN-1:0] generation;

  life_evo_sequencer #(
    .GRID_W(GW), .GRID_H(GH), .ADDR_W(AW), .TICK_PERIOD(TP), .GEN_W(GN)
  ) dut (
    .clk_vga(clk_vga), .reset_btn(reset_btn),
    .cmd_start(cmd_start), .cmd_pause(cmd_pause), .cmd_clear(cmd_clear),
    .cmd_step(cmd_step), .cmd_manual(cmd_manual), .dir(dir), .speed_sel(speed_sel),
    .init_busy(init_busy), .round_busy(round_busy), .state(state),
    .evo_bank(evo_bank), .evo_start(evo_start), .clear_req(clear_req),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .cursor_addr(cursor_addr),
    .generation(generation), .overrun(overrun)
  );

  always #5 clk_vga = ~clk_vga;

  typedef struct {
    int st; int bank; int evo; int clr; int x; int y; int addr; int gen; int ovr;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model state.
  int m_state, m_ret, m_tick, m_bank, m_evo, m_clr, m_gen, m_ovr, m_x, m_y;
  // Engine emulation for stimulus.
  int busy_left = 0, init_left = 0;
  bit busy_arm = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = S_RST; m_ret = S_RST; m_tick = 0; m_bank = 0; m_evo = 0; m_clr = 0;
    m_gen = 0; m_ovr = 0; m_x = GW / 2; m_y = GH / 2;
  endtask

  task automatic move_cursor();
    case (dir)
      4'b0001: if (m_x > 0) m_x--; else if (WRAP) m_x = GW - 1;
      4'b1000: if (m_x < GW - 1) m_x++; else if (WRAP) m_x = 0;
      4'b0010: if (m_y > 0) m_y--; else if (WRAP) m_y = GH - 1;
      4'b0100: if (m_y < GH - 1) m_y++; else if (WRAP) m_y = 0;
      default: begin end
    endcase
  endtask

  task automatic model_step();
    int ns, period;
    bit evo_n, do_clr;
    ns = m_state; evo_n = 0; do_clr = 0;
    period = TP * (1 << int'(speed_sel));
    case (m_state)
      S_RST: if (!init_busy) begin
        if (cmd_start) ns = S_PAUSE;
        else if (cmd_manual) begin ns = S_SET; m_ret = S_RST; end
      end
      S_RUN: begin
        if (cmd_clear) do_clr = 1;
        else if (cmd_pause) ns = S_PAUSE;
        else if (m_tick >= period - 1) begin
          if (!round_busy) begin
            m_tick = 0; m_bank ^= 1; evo_n = 1; m_gen = (m_gen + 1) % (1 << GN);
          end else m_ovr = 1;
        end else m_tick++;
      end
      S_PAUSE: begin
        if (cmd_clear) do_clr = 1;
        else if (!cmd_pause) begin
          if (cmd_step) begin
            ns = S_STEP; m_bank ^= 1; evo_n = 1; m_gen = (m_gen + 1) % (1 << GN);
          end else if (cmd_start) ns = S_RUN;
          else if (cmd_manual) begin ns = S_SET; m_ret = S_PAUSE; end
        end
      end
      S_STEP: begin
        if (cmd_clear) do_clr = 1;
        else if (m_evo == 0 && !round_busy) ns = S_PAUSE;
      end
      S_SET: begin
        if (cmd_clear) do_clr = 1;
        else if (!cmd_manual) ns = m_ret;
        else move_cursor();
      end
      default: ns = S_RST;
    endcase
    m_clr = 0;
    if (do_clr) begin
      ns = S_RST; m_tick = 0; m_bank = 0; m_gen = 0; m_ovr = 0; m_clr = 1; evo_n = 0;
    end
    m_state = ns;
    m_evo   = evo_n;
  endtask

  // Predict the next edge from the inputs now applied, queue it, move on.
  task automatic tick_cycle();
    exp_t e;
    if (reset_btn) model_reset(); else model_step();
    e.st = m_state; e.bank = m_bank; e.evo = m_evo; e.clr = m_clr; e.x = m_x; e.y = m_y;
    e.addr = m_y * GW + m_x; e.gen = m_gen; e.ovr = m_ovr;
    sb_q.push_back(e);
    @(negedge clk_vga);
  endtask

  always @(posedge clk_vga) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("state", int'(state), e.st);
      check("evo_bank", int'(evo_bank), e.bank);
      check("evo_start", int'(evo_start), e.evo);
      check("clear_req", int'(clear_req), e.clr);
      check("cursor_x", int'(cursor_x), e.x);
      check("cursor_y", int'(cursor_y), e.y);
      check("cursor_addr", int'(cursor_addr), e.addr);
      check("generation", int'(generation), e.gen);
      check("overrun", int'(overrun), e.ovr);
    end
  end

  task automatic idle();
    cmd_start = 0; cmd_pause = 0; cmd_clear = 0; cmd_step = 0; dir = 4'b0000;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) tick_cycle();
  endtask

  task automatic pulse_cycle(input int which);
    case (which)
      0: cmd_start = 1;
      1: cmd_pause = 1;
      2: cmd_step  = 1;
      default: cmd_clear = 1;
    endcase
    tick_cycle();
    idle();
  endtask

  initial begin
    idle();
    cmd_manual = 0; speed_sel = 2'd0; init_busy = 0; round_busy = 0; reset_btn = 1;
    model_reset();
    @(negedge clk_vga);
    cycles(2);
    reset_btn = 0;

    // init_busy blocks start.
    init_busy = 1; cmd_start = 1; cycles(3);
    init_busy = 0; idle();
    pulse_cycle(0);              // RST -> PAUSE
    pulse_cycle(0);              // PAUSE -> RUN
    cycles(13);                  // three generations at period 4
    cmd_clear = 1; cmd_pause = 1; tick_cycle(); idle();

    // Overrun at speed 2.
    pulse_cycle(0); pulse_cycle(0);
    speed_sel = 2'd2; round_busy = 1; cycles(20);
    round_busy = 0; cycles(2);
    pulse_cycle(1);              // -> PAUSE
    speed_sel = 2'd0;

    // Single step with 5 busy cycles.
    pulse_cycle(2);
    cycles(1);
    round_busy = 1; cycles(5);
    round_busy = 0; cycles(2);

    // Cursor walk to (0,0) and past the edges.
    cmd_manual = 1; cycles(1);
    dir = 4'b0001; cycles(GW);
    dir = 4'b0010; cycles(GH);
    dir = 4'b1000; cycles(2);
    dir = 4'b0100; cycles(1);
    dir = 4'b0011; cycles(1);
    dir = 4'b1111; cycles(1);
    idle(); cmd_manual = 0; cycles(2);

    // Reset during STEP aborts immediately.
    pulse_cycle(2);
    reset_btn = 1;
    #1;
    check("reset_state", int'(state), S_RST);
    check("reset_evo_start", int'(evo_start), 0);
    tick_cycle();
    reset_btn = 0;
    init_busy = 1; cmd_start = 1; cycles(2);
    init_busy = 0; idle(); cycles(1);

    // Randomised phase with emulated engines.
    for (int n = 0; n < 8000; n++) begin
      int r;
      reset_btn = ($urandom_range(0, 1999) == 0);
      cmd_clear = ($urandom_range(0, 299) == 0);
      cmd_pause = ($urandom_range(0, 59) == 0);
      cmd_step  = ($urandom_range(0, 19) == 0);
      cmd_start = ($urandom_range(0, 14) == 0);
      if ($urandom_range(0, 39) == 0) cmd_manual = ~cmd_manual;
      r = $urandom_range(0, 9);
      if (r < 5) dir = 4'b0001 << $urandom_range(0, 3);
      else if (r < 7) dir = 4'($urandom);
      else dir = 4'b0000;
      if ($urandom_range(0, 99) == 0) speed_sel = 2'($urandom);
      if (busy_arm) begin busy_left = $urandom_range(0, 8); busy_arm = 0; end
      round_busy = (busy_left > 0) || ($urandom_range(0, 99) == 0);
      if (busy_left > 0) busy_left--;
      if (m_evo != 0) busy_arm = 1;
      if (m_clr != 0) init_left = $urandom_range(0, 10);
      init_busy = (init_left > 0);
      if (init_left > 0) init_left--;
      tick_cycle();
    end

    idle(); reset_btn = 0;
    @(negedge clk_vga);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
